// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-memory side of the core: loader FSM
// encoding plus address/word geometry also used by imem and the PC adder.
package mips_pkg;

   localparam int IMEM_ADDR_W = 10;
   localparam int WORD_BYTES  = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } ld_state_t;

endpackage

// File: rtl/byte_packer.sv
// Big-endian byte-to-word packer: the first byte of a word ends up in [31:24].
// word_next is the value the word takes with the byte on byte_in shifted in.
module byte_packer (
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic        clr,
   input  logic        shift_en,
   input  logic [7:0]  byte_in,
   output logic [31:0] word_next,
   output logic        word_full
);

   logic [31:0] word;
   logic [1:0]  byte_cnt;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         word     <= '0;
         byte_cnt <= '0;
      end else if (clr) begin
         word     <= '0;
         byte_cnt <= '0;
      end else if (shift_en) begin
         word     <= word_next;
         byte_cnt <= byte_cnt + 2'd1;
      end
   end

   assign word_next = {word[23:0], byte_in};
   // High in the cycle the 4th byte of a word is being accepted.
   assign word_full = shift_en && (byte_cnt == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Writer side of the instruction memory: packs a valid/ready byte stream into
// big-endian words at consecutive addresses while holding the CPU in reset.
module imem_loader
   import mips_pkg::*;
#(
   parameter int ADDR_W    = IMEM_ADDR_W,
   parameter int BASE_ADDR = 0
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic              START,
   input  logic [ADDR_W-1:0] WORD_COUNT,
   input  logic [7:0]        BYTE_IN,
   input  logic              BYTE_VALID,
   output logic              BYTE_READY,
   output logic              IMEM_WE,
   output logic [ADDR_W-1:0] IMEM_ADDR,
   output logic [31:0]       IMEM_WDATA,
   output logic              CPU_HOLD,
   output logic              BUSY,
   output logic              DONE,
   output logic              ERR,
   output logic [7:0]        CHECKSUM
);

   localparam int DEPTH_W   = 2 ** (ADDR_W - 2);
   localparam int MAX_WORDS = DEPTH_W - BASE_ADDR / WORD_BYTES;

   ld_state_t         state, nstate;
   logic [ADDR_W-1:0] words_left, addr_q, addr_out;
   logic [31:0]       wdata_q, pk_next;
   logic              pk_full;
   logic [7:0]        cksum;
   logic              done_q, err_q;
   logic              start_acc, too_big, byte_acc;

   assign start_acc = START && (state == ST_IDLE || state == ST_DONE);
   assign too_big   = {1'b0, WORD_COUNT} > (ADDR_W + 1)'(MAX_WORDS);
   assign byte_acc  = BYTE_VALID && (state == ST_LOAD);

   byte_packer u_packer (
      .CLK       (CLK),
      .RESET_N   (RESET_N),
      .clr       (start_acc),
      .shift_en  (byte_acc),
      .byte_in   (BYTE_IN),
      .word_next (pk_next),
      .word_full (pk_full)
   );

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) state <= ST_IDLE;
      else          state <= nstate;
   end

   always_comb begin
      nstate = state;
      case (state)
         ST_IDLE, ST_DONE:
            if (start_acc) begin
               if (too_big)                 nstate = ST_IDLE;
               else if (WORD_COUNT == '0)   nstate = ST_DONE;
               else                         nstate = ST_LOAD;
            end
         ST_LOAD:  if (pk_full) nstate = ST_WRITE;
         ST_WRITE: nstate = (words_left == ADDR_W'(1)) ? ST_DONE : ST_LOAD;
         default:  nstate = ST_IDLE;
      endcase
   end

   // Write address/data are captured with the 4th byte so they hold steady
   // outside WRITE while the packer refills.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         words_left <= '0;
         addr_q     <= '0;
         addr_out   <= '0;
         wdata_q    <= '0;
         cksum      <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else if (start_acc) begin
         words_left <= WORD_COUNT;
         addr_q     <= ADDR_W'(BASE_ADDR);
         cksum      <= '0;
         done_q     <= !too_big && (WORD_COUNT == '0);
         err_q      <= too_big;
      end else begin
         if (byte_acc) cksum <= cksum + BYTE_IN;
         if (pk_full) begin
            wdata_q  <= pk_next;
            addr_out <= addr_q;
         end
         if (state == ST_WRITE) begin
            addr_q     <= addr_q + ADDR_W'(WORD_BYTES);
            words_left <= words_left - ADDR_W'(1);
            if (words_left == ADDR_W'(1)) done_q <= 1'b1;
         end
      end
   end

   always_comb begin
      BYTE_READY = (state == ST_LOAD);
      IMEM_WE    = (state == ST_WRITE);
      BUSY       = (state == ST_LOAD) || (state == ST_WRITE);
      CPU_HOLD   = BUSY;
   end

   assign IMEM_ADDR  = addr_out;
   assign IMEM_WDATA = wdata_q;
   assign DONE       = done_q;
   assign ERR        = err_q;
   assign CHECKSUM   = cksum;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a cycle table for a 2-word load, then
// hand-written sequences for stalls, zero/oversize counts, START and reset.
module tb_imem_loader;

   logic        CLK = 1'b0;
   logic        RESET_N = 1'b0;
   logic        START = 1'b0;
   logic [9:0]  WORD_COUNT = '0;
   logic [7:0]  BYTE_IN = '0;
   logic        BYTE_VALID = 1'b0;
   logic        BYTE_READY, IMEM_WE, CPU_HOLD, BUSY, DONE, ERR;
   logic [9:0]  IMEM_ADDR;
   logic [31:0] IMEM_WDATA;
   logic [7:0]  CHECKSUM;

   imem_loader #(.ADDR_W(10), .BASE_ADDR(0)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .START(START), .WORD_COUNT(WORD_COUNT),
      .BYTE_IN(BYTE_IN), .BYTE_VALID(BYTE_VALID), .BYTE_READY(BYTE_READY),
      .IMEM_WE(IMEM_WE), .IMEM_ADDR(IMEM_ADDR), .IMEM_WDATA(IMEM_WDATA),
      .CPU_HOLD(CPU_HOLD), .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .CHECKSUM(CHECKSUM)
   );

   always #5 CLK = ~CLK;

   int          n_chk = 0, n_bad = 0;
   logic [9:0]  wq_addr[$];
   logic [31:0] wq_data[$];
   logic [31:0] mem [0:255];
   int          we_ready_bad = 0;
   bit          hold_seen = 0;
   logic [7:0]  byte_q[$];

   // Memory-side model: one logged write per cycle of IMEM_WE.
   always @(negedge CLK) begin
      if (IMEM_WE) begin
         wq_addr.push_back(IMEM_ADDR);
         wq_data.push_back(IMEM_WDATA);
         mem[IMEM_ADDR[9:2]] = IMEM_WDATA;
         if (BYTE_READY) we_ready_bad++;
      end
      if (CPU_HOLD) hold_seen = 1;
   end

   typedef struct {
      logic       start;
      logic [9:0] wc;
      logic [7:0] b;
      logic       v;
      logic [55:0] exp;
   } vec_t;

   function automatic logic [55:0] ev(logic r, logic we, logic [9:0] a, logic [31:0] d,
                                      logic h, logic bz, logic dn, logic er, logic [7:0] ck);
      return {r, we, a, d, h, bz, dn, er, ck};
   endfunction

   function automatic logic [55:0] outs();
      return {BYTE_READY, IMEM_WE, IMEM_ADDR, IMEM_WDATA, CPU_HOLD, BUSY, DONE, ERR, CHECKSUM};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK); #1;
   endtask

   // Drives bytes from byte_q until empty or stop_after bytes accepted.
   task automatic feed(input bit toggle, input int stop_after);
      int cyc = 0, acc = 0;
      bit ph = 0;
      while (byte_q.size() > 0 && acc < stop_after && cyc < 500) begin
         BYTE_VALID = toggle ? ph : 1'b1;
         ph = ~ph;
         BYTE_IN = byte_q[0];
         #1;
         if (BYTE_VALID && BYTE_READY) begin
            void'(byte_q.pop_front());
            acc++;
         end
         @(posedge CLK); #1;
         cyc++;
      end
      BYTE_VALID = 1'b0;
      if (cyc >= 500) chk("feed_timeout", 64'(cyc), 64'(0));
   endtask

   task automatic wait_done(input int bound);
      int c = 0;
      while (!DONE && c < bound) begin tick(); c++; end
      chk("done_reached", 64'(DONE), 64'(1));
   endtask

   task automatic start_load(input logic [9:0] wc);
      START = 1'b1; WORD_COUNT = wc;
      tick();
      START = 1'b0;
   endtask

   vec_t vecs[12];
   int   mark;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      #1 chk("reset_outs", 64'(outs()), 64'(0));
      #8 RESET_N = 1'b1;
      tick();

      // 2-word load, BYTE_VALID held high; START cycle does not consume the byte.
      vecs[0]  = '{1, 10'd2, 8'h00, 1, ev(1,0,10'h000,32'h0,       1,1,0,0,8'h00)};
      vecs[1]  = '{0, 10'd2, 8'h00, 1, ev(1,0,10'h000,32'h0,       1,1,0,0,8'h00)};
      vecs[2]  = '{0, 10'd2, 8'h01, 1, ev(1,0,10'h000,32'h0,       1,1,0,0,8'h01)};
      vecs[3]  = '{0, 10'd2, 8'h10, 1, ev(1,0,10'h000,32'h0,       1,1,0,0,8'h11)};
      vecs[4]  = '{0, 10'd2, 8'h20, 1, ev(0,1,10'h000,32'h00011020,1,1,0,0,8'h31)};
      vecs[5]  = '{0, 10'd2, 8'h00, 1, ev(1,0,10'h000,32'h00011020,1,1,0,0,8'h31)};
      vecs[6]  = '{0, 10'd2, 8'h00, 1, ev(1,0,10'h000,32'h00011020,1,1,0,0,8'h31)};
      vecs[7]  = '{0, 10'd2, 8'h64, 1, ev(1,0,10'h000,32'h00011020,1,1,0,0,8'h95)};
      vecs[8]  = '{0, 10'd2, 8'h28, 1, ev(1,0,10'h000,32'h00011020,1,1,0,0,8'hBD)};
      vecs[9]  = '{0, 10'd2, 8'h24, 1, ev(0,1,10'h004,32'h00642824,1,1,0,0,8'hE1)};
      vecs[10] = '{0, 10'd2, 8'h00, 0, ev(0,0,10'h004,32'h00642824,0,0,1,0,8'hE1)};
      vecs[11] = '{0, 10'd2, 8'hFF, 1, ev(0,0,10'h004,32'h00642824,0,0,1,0,8'hE1)};
      for (int i = 0; i < 12; i++) begin
         START = vecs[i].start; WORD_COUNT = vecs[i].wc;
         BYTE_IN = vecs[i].b;   BYTE_VALID = vecs[i].v;
         tick();
         chk($sformatf("vec%0d", i), 64'(outs()), 64'(vecs[i].exp));
      end
      START = 0; BYTE_VALID = 0;

      // 3 words with BYTE_VALID toggling.
      mark = wq_addr.size(); we_ready_bad = 0;
      byte_q = '{8'h11,8'h22,8'h33,8'h44,8'h55,8'h66,8'h77,8'h88,8'h99,8'hAA,8'hBB,8'hCC};
      start_load(10'd3);
      feed(1, 100);
      wait_done(20);
      chk("t2_nwr", 64'(wq_addr.size() - mark), 64'(3));
      if (wq_addr.size() == mark + 3) begin
         chk("t2_a0", 64'(wq_addr[mark]),   64'(10'h000));
         chk("t2_a1", 64'(wq_addr[mark+1]), 64'(10'h004));
         chk("t2_a2", 64'(wq_addr[mark+2]), 64'(10'h008));
         chk("t2_d0", 64'(wq_data[mark]),   64'(32'h11223344));
         chk("t2_d1", 64'(wq_data[mark+1]), 64'(32'h55667788));
         chk("t2_d2", 64'(wq_data[mark+2]), 64'(32'h99AABBCC));
      end
      chk("t2_ready_in_write", 64'(we_ready_bad), 64'(0));
      chk("t2_cksum", 64'(CHECKSUM), 64'(8'h2E));
      chk("t2_hold_done", 64'(CPU_HOLD), 64'(0));

      // WORD_COUNT = 0.
      mark = wq_addr.size(); hold_seen = 0;
      start_load(10'd0);
      chk("t3_flags", 64'({DONE, BUSY, ERR, CPU_HOLD}), 64'(4'b1000));
      tick(); tick();
      chk("t3_hold", 64'(hold_seen), 64'(0));
      chk("t3_nwr", 64'(wq_addr.size() - mark), 64'(0));

      // Oversized count from DONE, then a normal 1-word load.
      mark = wq_addr.size(); hold_seen = 0;
      start_load(10'd257);
      chk("t4_flags", 64'({ERR, DONE, BUSY, CPU_HOLD, BYTE_READY}), 64'(5'b10000));
      BYTE_VALID = 1; BYTE_IN = 8'h77;
      tick(); tick();
      BYTE_VALID = 0;
      chk("t4_idle", 64'({ERR, BUSY, CHECKSUM}), 64'({1'b1, 1'b0, 8'h00}));
      chk("t4_nowr", 64'(wq_addr.size() - mark + int'(hold_seen)), 64'(0));
      start_load(10'd1);
      chk("t4_err_clr", 64'({ERR, BYTE_READY}), 64'(2'b01));
      byte_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      feed(0, 100);
      wait_done(10);
      chk("t4_nwr", 64'(wq_addr.size() - mark), 64'(1));
      if (wq_addr.size() == mark + 1)
         chk("t4_wr", 64'({wq_addr[mark], wq_data[mark]}), 64'({10'h000, 32'hDEADBEEF}));

      // START pulsed during a load is ignored.
      mark = wq_addr.size();
      byte_q = '{8'h01,8'h02,8'h03,8'h04,8'h05,8'h06,8'h07,8'h08};
      start_load(10'd2);
      feed(0, 2);
      START = 1; WORD_COUNT = 10'd7;
      feed(0, 1);
      START = 0;
      feed(0, 100);
      wait_done(10);
      chk("t5_nwr", 64'(wq_addr.size() - mark), 64'(2));
      if (wq_addr.size() == mark + 2) begin
         chk("t5_w0", 64'({wq_addr[mark],   wq_data[mark]}),   64'({10'h000, 32'h01020304}));
         chk("t5_w1", 64'({wq_addr[mark+1], wq_data[mark+1]}), 64'({10'h004, 32'h05060708}));
      end
      chk("t5_cksum", 64'(CHECKSUM), 64'(8'h24));

      // Asynchronous reset after 5 bytes of a 2-word load.
      mark = wq_addr.size();
      byte_q = '{8'hA1,8'hA2,8'hA3,8'hA4,8'hB1,8'hB2,8'hB3,8'hB4};
      start_load(10'd2);
      feed(0, 5);
      chk("t6_busy", 64'({BUSY, CPU_HOLD}), 64'(2'b11));
      #2 RESET_N = 1'b0;
      #1 chk("t6_reset_outs", 64'(outs()), 64'(0));
      #5 RESET_N = 1'b1;
      tick(); tick();
      chk("t6_nwr", 64'(wq_addr.size() - mark), 64'(1));
      chk("t6_mem0", 64'(mem[0]), 64'(32'hA1A2A3A4));
      chk("t6_after", 64'({DONE, BUSY, CPU_HOLD}), 64'(3'b000));

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
